// File: rtl/trace_update.sv
// Per-timestep synaptic trace engine: decays and spike-increments 24 presynaptic
// and 18 postsynaptic traces through one time-multiplexed datapath, one index per cycle.
module trace_update #(
    parameter int unsigned X_SHIFT  = 4,
    parameter int unsigned Y1_SHIFT = 4,
    parameter int unsigned Y2_SHIFT = 5,
    parameter logic [15:0] X_INC    = 16'h4000,
    parameter logic [15:0] Y1_INC   = 16'h4000,
    parameter logic [15:0] Y2_INC   = 16'h2000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_run,
    input  logic         i_clear,
    input  logic [23:0]  i_pre_spike,
    input  logic [17:0]  i_post_spike,
    output logic [383:0] o_x_trace,
    output logic [287:0] o_y1_trace,
    output logic [287:0] o_y2_trace_buf,
    output logic         o_busy,
    output logic         o_done
);

    typedef enum logic [1:0] {
        IDLE,
        X_UPD,
        Y_UPD,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [23:0] pre_lat;
    logic [17:0] post_lat;

    logic [15:0] x_r      [24];
    logic [15:0] y1_r     [18];
    logic [15:0] y2_r     [18];
    logic [15:0] y2_buf_r [18];

    // Small traces decay by at least 1 so every trace eventually reaches zero.
    function automatic logic [15:0] decay(input logic [15:0] t, input int unsigned s);
        logic [15:0] step;
        step = t >> s;
        if (step != '0)
            return t - step;
        else if (t != '0)
            return t - 16'd1;
        else
            return '0;
    endfunction

    function automatic logic [15:0] bump(input logic [15:0] d, input logic [15:0] inc,
                                         input logic spike);
        logic [16:0] sum;
        sum = {1'b0, d} + {1'b0, inc};
        if (!spike)
            return d;
        return sum[16] ? '1 : sum[15:0];
    endfunction

    // Lane A serves x during X_UPD and y1 during Y_UPD; lane B serves y2.
    logic              a_is_x;
    logic [15:0]       a_cur;
    logic [15:0]       a_inc;
    int unsigned       a_shift;
    logic              a_spk;
    logic [15:0]       a_new;
    logic [15:0]       b_cur;
    logic [15:0]       b_new;

    always_comb begin
        a_is_x  = (state == X_UPD);
        a_cur   = '0;
        a_spk   = 1'b0;
        a_shift = a_is_x ? X_SHIFT : Y1_SHIFT;
        a_inc   = a_is_x ? X_INC : Y1_INC;
        b_cur   = '0;
        if (a_is_x) begin
            a_cur = x_r[idx];
            a_spk = pre_lat[idx];
        end else if (state == Y_UPD) begin
            a_cur = y1_r[idx];
            a_spk = post_lat[idx];
            b_cur = y2_r[idx];
        end
        a_new = bump(decay(a_cur, a_shift), a_inc, a_spk);
        b_new = bump(decay(b_cur, Y2_SHIFT), Y2_INC, (state == Y_UPD) && post_lat[idx]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            pre_lat  <= '0;
            post_lat <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            for (int unsigned i = 0; i < 24; i++)
                x_r[i] <= '0;
            for (int unsigned j = 0; j < 18; j++) begin
                y1_r[j]     <= '0;
                y2_r[j]     <= '0;
                y2_buf_r[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_clear) begin
                        for (int unsigned i = 0; i < 24; i++)
                            x_r[i] <= '0;
                        for (int unsigned j = 0; j < 18; j++) begin
                            y1_r[j]     <= '0;
                            y2_r[j]     <= '0;
                            y2_buf_r[j] <= '0;
                        end
                    end else if (i_run) begin
                        state    <= X_UPD;
                        idx      <= '0;
                        pre_lat  <= i_pre_spike;
                        post_lat <= i_post_spike;
                        o_busy   <= 1'b1;
                    end
                end
                X_UPD: begin
                    x_r[idx] <= a_new;
                    if (idx == 5'd23) begin
                        idx   <= '0;
                        state <= Y_UPD;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                Y_UPD: begin
                    y1_r[idx]     <= a_new;
                    y2_r[idx]     <= b_new;
                    y2_buf_r[idx] <= y2_r[idx];
                    if (idx == 5'd17) begin
                        idx    <= '0;
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    idx    <= '0;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_x_trace      = '0;
        o_y1_trace     = '0;
        o_y2_trace_buf = '0;
        for (int unsigned i = 0; i < 24; i++)
            o_x_trace[16*i +: 16] = x_r[i];
        for (int unsigned j = 0; j < 18; j++) begin
            o_y1_trace[16*j +: 16]     = y1_r[j];
            o_y2_trace_buf[16*j +: 16] = y2_buf_r[j];
        end
    end

endmodule

// File: tb/tb_trace_update.sv
// Randomized self-checking bench for trace_update: two instances (default and
// X_INC=5) driven in lockstep against an integer reference model of the trace rules.
module tb_trace_update;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_run;
    logic         i_clear;
    logic [23:0]  i_pre_spike;
    logic [17:0]  i_post_spike;
    logic [383:0] x_a, x_b;
    logic [287:0] y1_a, y1_b, buf_a, buf_b;
    logic         busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    trace_update dut_a (
        .clk(clk), .reset(reset), .i_run(i_run), .i_clear(i_clear),
        .i_pre_spike(i_pre_spike), .i_post_spike(i_post_spike),
        .o_x_trace(x_a), .o_y1_trace(y1_a), .o_y2_trace_buf(buf_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    trace_update #(.X_INC(16'd5)) dut_b (
        .clk(clk), .reset(reset), .i_run(i_run), .i_clear(i_clear),
        .i_pre_spike(i_pre_spike), .i_post_spike(i_post_spike),
        .o_x_trace(x_b), .o_y1_trace(y1_b), .o_y2_trace_buf(buf_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference traces as plain integers; index 0 of mx is dut_a, index 1 is dut_b.
    int mx [2][24];
    int my1 [18];
    int my2 [18];
    int mbuf [18];

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_next(input int t, input int s, input int inc, input bit spk);
        int loss, r;
        loss = t / (1 << s);
        if (loss == 0 && t > 0)
            loss = 1;
        r = t - loss;
        if (spk)
            r = (r + inc > 65535) ? 65535 : r + inc;
        return r;
    endfunction

    task automatic model_step(input logic [23:0] pre, input logic [17:0] post);
        for (int i = 0; i < 24; i++) begin
            mx[0][i] = ref_next(mx[0][i], 4, 16384, pre[i]);
            mx[1][i] = ref_next(mx[1][i], 4, 5, pre[i]);
        end
        for (int j = 0; j < 18; j++) begin
            mbuf[j] = my2[j];
            my1[j]  = ref_next(my1[j], 4, 16384, post[j]);
            my2[j]  = ref_next(my2[j], 5, 8192, post[j]);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 24; i++) begin
            mx[0][i] = 0;
            mx[1][i] = 0;
        end
        for (int j = 0; j < 18; j++) begin
            my1[j]  = 0;
            my2[j]  = 0;
            mbuf[j] = 0;
        end
    endtask

    function automatic logic [383:0] pack_x(input int k);
        logic [383:0] v;
        v = '0;
        for (int i = 0; i < 24; i++)
            v[16*i +: 16] = 16'(mx[k][i]);
        return v;
    endfunction

    function automatic logic [287:0] pack_y(input int a [18]);
        logic [287:0] v;
        v = '0;
        for (int j = 0; j < 18; j++)
            v[16*j +: 16] = 16'(a[j]);
        return v;
    endfunction

    function automatic logic [383:0] xel(input logic [383:0] b, input int i);
        return 384'(b[16*i +: 16]);
    endfunction

    function automatic logic [383:0] yel(input logic [287:0] b, input int j);
        return 384'(b[16*j +: 16]);
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_x_a"}, x_a, pack_x(0));
        check({tag, "_x_b"}, x_b, pack_x(1));
        check({tag, "_y1_a"}, 384'(y1_a), 384'(pack_y(my1)));
        check({tag, "_y1_b"}, 384'(y1_b), 384'(pack_y(my1)));
        check({tag, "_buf_a"}, 384'(buf_a), 384'(pack_y(mbuf)));
        check({tag, "_buf_b"}, 384'(buf_b), 384'(pack_y(mbuf)));
        check({tag, "_ctl"}, 384'({busy_a, done_a, busy_b, done_b}), 384'(0));
    endtask

    task automatic scramble_spikes();
        logic [31:0] r;
        r = $urandom;
        i_pre_spike = r[23:0];
        r = $urandom;
        i_post_spike = r[17:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        i_run   = 1'b0;
        i_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_zero();
        check_all("reset");
    endtask

    // Starts at a negedge in IDLE; i_run is high in cycle 0. Optional mid-run
    // i_run (rerun_cyc), i_clear (clr_cyc) and reset (rst_cyc); 0 disables each.
    task automatic run_step(input logic [23:0] pre, input logic [17:0] post,
                            input int rerun_cyc, input int clr_cyc, input int rst_cyc);
        int  bad, ndone, done_at;
        bit  aborted;
        bad     = 0;
        ndone   = 0;
        done_at = 0;
        aborted = 1'b0;
        i_run        = 1'b1;
        i_pre_spike  = pre;
        i_post_spike = post;
        for (int cyc = 1; cyc <= 44 && !aborted; cyc++) begin
            @(negedge clk);
            if (rst_cyc != 0 && cyc > rst_cyc) begin
                reset = 1'b0;
                model_zero();
                check_all("rst_mid");
                check("rst_nodone", 384'(ndone), 384'(0));
                aborted = 1'b1;
            end else begin
                if (busy_a !== (cyc <= 43) || busy_b !== (cyc <= 43))
                    bad++;
                if (done_a !== done_b)
                    bad++;
                if (done_a === 1'b1) begin
                    ndone++;
                    if (done_at == 0)
                        done_at = cyc;
                end
                i_run   = (cyc == rerun_cyc);
                i_clear = (cyc == clr_cyc);
                reset   = (cyc == rst_cyc);
                scramble_spikes();
            end
        end
        i_run   = 1'b0;
        i_clear = 1'b0;
        if (!aborted) begin
            check("busy_seq", 384'(bad), 384'(0));
            check("done_cyc", 384'(done_at), 384'(43));
            check("done_cnt", 384'(ndone), 384'(1));
            model_step(pre, post);
            check_all("step");
        end
    endtask

    initial begin
        logic [31:0] r1, r2;
        reset        = 1'b1;
        i_run        = 1'b0;
        i_clear      = 1'b0;
        i_pre_spike  = '0;
        i_post_spike = '0;
        model_zero();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all("por");

        run_step('0, '0, 0, 0, 0);

        do_reset();
        run_step(24'h000001, '0, 0, 0, 0);
        check("x0_s1", xel(x_a, 0), 384'('h4000));
        run_step('0, '0, 0, 0, 0);
        check("x0_s2", xel(x_a, 0), 384'('h3C00));

        do_reset();
        run_step('0, 18'h00020, 0, 0, 0);
        check("y1_5_s1", yel(y1_a, 5), 384'('h4000));
        check("buf5_s1", yel(buf_a, 5), 384'('h0));
        run_step('0, 18'h00020, 0, 0, 0);
        check("y1_5_s2", yel(y1_a, 5), 384'('h7C00));
        check("buf5_s2", yel(buf_a, 5), 384'('h2000));
        run_step('0, '0, 0, 0, 0);
        check("buf5_s3", yel(buf_a, 5), 384'('h3F00));

        do_reset();
        repeat (5) run_step(24'h800000, '0, 0, 0, 0);
        check("x23_sat", xel(x_a, 23), 384'('hFFFF));
        run_step(24'h800000, '0, 0, 0, 0);
        check("x23_hold", xel(x_a, 23), 384'('hFFFF));
        run_step('0, '0, 0, 0, 0);
        check("x23_dec", xel(x_a, 23), 384'('hF000));

        do_reset();
        run_step(24'h000008, '0, 0, 0, 0);
        check("x3_pre", xel(x_b, 3), 384'('d5));
        for (int k = 4; k >= -1; k--) begin
            run_step('0, '0, 0, 0, 0);
            check("x3_small", xel(x_b, 3), 384'(k < 0 ? 0 : k));
        end

        do_reset();
        run_step(24'hA5A5A5, 18'h2A5A5, 10, 12, 0);

        run_step(24'h0F0F0F, 18'h3C3C3, 0, 0, 30);

        run_step(24'hFFFFFF, 18'h3FFFF, 0, 0, 0);
        @(negedge clk);
        i_clear = 1'b1;
        i_run   = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        i_run   = 1'b0;
        model_zero();
        check_all("clr_run");
        @(negedge clk);
        check("clr_idle", 384'({busy_a, busy_b}), 384'(0));

        for (int s = 0; s < 40; s++) begin
            r1 = $urandom;
            r2 = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                i_clear = 1'b1;
                @(negedge clk);
                i_clear = 1'b0;
                model_zero();
                check_all("rnd_clr");
            end
            run_step(r1[23:0], r2[17:0],
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 42)) : 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 42)) : 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_update.md
Name: trace_update

Overview:
- Per-timestep synaptic trace engine sitting directly upstream of the STDP weight-update stage.
- On each start pulse it decays and spike-increments 24 presynaptic traces (x) and 18 postsynaptic traces (y1, y2).
- It also snapshots the pre-update y2 values into y2_buf. Its three trace buses and done pulse feed the STDP stage's x_trace, y1_trace and y2_trace_buf inputs and its run input.
- A single shared decay/increment datapath is time-multiplexed, one trace index per cycle.

Parameters:
- X_SHIFT, 4, x decay shift (x -= x>>X_SHIFT)
- Y1_SHIFT, 4, y1 decay shift
- Y2_SHIFT, 5, y2 decay shift
- X_INC, 16'h4000, x increment on presynaptic spike
- Y1_INC, 16'h4000, y1 increment on postsynaptic spike
- Y2_INC, 16'h2000, y2 increment on postsynaptic spike

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- i_run  input  1  single-cycle start pulse for one timestep
- i_clear  input  1  zero all traces (honoured only in IDLE)
- i_pre_spike  input  24  presynaptic spikes for this timestep
- i_post_spike  input  18  postsynaptic spikes for this timestep
- o_x_trace  output  384  x[i] at bits 16*i +: 16
- o_y1_trace  output  288  y1[j] at bits 16*j +: 16
- o_y2_trace_buf  output  288  y2[j] value before this timestep's update
- o_busy  output  1  high in any state other than IDLE
- o_done  output  1  one-cycle pulse when all traces are updated

Behaviour:
- Reset: one clock, synchronous, active-high. It is fixed by design. Reset clears all trace registers, y2 trace, y2_buf, spike latches and index counter, forces FSM to IDLE, and drives o_busy=0 and o_done=0.
- Reset mid-operation aborts the update. All traces return to 0 on the next edge, and no o_done is produced.
- FSM states: IDLE, X_UPD, Y_UPD, DONE.
  - IDLE -> X_UPD when i_run=1.
  - X_UPD -> Y_UPD after index 23.
  - Y_UPD -> DONE after index 17.
  - DONE -> IDLE unconditionally.
- Spike latching: in the i_run cycle, i_pre_spike and i_post_spike are registered. Later changes on the spike inputs have no effect on the current timestep.
- Index counter: 5 bits, starts at 0 on entering X_UPD, increments each cycle, and resets to 0 at X_UPD->Y_UPD and at DONE.
- Timing, with i_run high in cycle 0:
  - Cycles 1..24 process x[0..23].
  - Cycles 25..42 process y1/y2[0..17].
  - Cycle 43 is DONE with o_done=1.
  - Cycle 44 is IDLE. Total latency is 43 cycles from i_run to o_done.
- Each processed element is written at the end of its cycle. Outputs are driven directly from the trace registers.
- Consumers sample the outputs only after o_done. Outputs are stable while IDLE/DONE and keep their values until the next i_run.
- Decay, 16-bit unsigned, for a trace t with shift S:
  - If (t>>S) != 0, d = t - (t>>S).
  - Else if t != 0, d = t - 1, so the trace is guaranteed to reach 0.
  - Else d = 0.
- Increment: if the latched spike is set, result = min(d + INC, 16'hFFFF), computed 17-bit then saturated. Otherwise result = d.
- Y_UPD index j, same cycle: y2_buf[j] <= current y2[j] (the pre-decay, pre-increment value). y1[j] and y2[j] update independently with their own shift and increment.
- i_run while o_busy=1 is ignored: no restart and no queueing.
- i_clear:
  - In IDLE it zeroes x, y1, y2 and y2_buf on the next edge.
  - i_clear with i_run in the same IDLE cycle: clear wins, i_run is ignored, and the FSM stays IDLE.
  - i_clear while busy is ignored.
- No arithmetic wraps. Underflow is impossible by construction, and overflow saturates at 16'hFFFF.

Test Plan:
- Reset, then a step with no spikes: all trace outputs are 0, o_done pulses exactly 43 cycles after i_run, and o_busy is high for cycles 1..43.
- Pre spike on bit 0 only: after step 1, x[0]=16'h4000. After step 2 with no spikes, x[0]=16'h3C00. All other x remain 0.
- Post spike on neuron 5 in steps 1 and 2:
  - After step 1: y1[5]=16'h4000, y2[5]=16'h2000, y2_buf[5]=0.
  - After step 2: y1[5]=16'h7C00, y2_buf[5]=16'h2000, y2[5]=16'h2000-16'h0100+16'h2000=16'h3F00.
- Saturation: spike x[23] on 5 consecutive steps, so x[23] reaches 16'hFFFF and holds at 16'hFFFF under further spikes. Then one non-spike step gives 16'hF000.
- Small-value decay: preload x[3]=5 via one step with X_INC=5 (parameter override), then no-spike steps give 4, 3, 2, 1, 0, 0.
- Control corners:
  - i_run re-asserted at cycle 10: no effect, single o_done at cycle 43.
  - reset at cycle 30: all outputs 0 next cycle, no o_done.
  - i_clear with i_run in IDLE: traces cleared, FSM stays IDLE.
